rr_arbiter_4: RTL and testbench

//  - Round-robin arbiter that shares one resource among 4 requesters.
//  - Registers a 2-bit winner index and drives a one-hot grant vector through a 2-to-4 decoder.
//  - Sits between requesting units and the shared datapath; the grant vector selects or enables the owner.

---
 rtl/rr_arbiter_4_pkg.sv | 21 ++
 rtl/rr_arbiter_4_if.sv | 44 ++++
 rtl/rr_arbiter_4_dec.sv | 26 ++
 rtl/rr_arbiter_4.sv | 161 ++++++++++++++++
 tb/tb_rr_arbiter_4.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4_pkg
// Description : Shared types and constants for the 4-way round-robin arbiter.
//               ST_IDLE / ST_BUSY : arbiter FSM state encoding (1 bit)
//               N_REQ             : number of requesters
//               IDX_W             : width of a requester index
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter_4_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage : rr_arbiter_4_pkg
`default_nettype wire

// File: rtl/rr_arbiter_4_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4_if
// Description : Request/grant bundle between the requesting units and the
//               round-robin arbiter.
//               req       : per-requester request, held until served
//               done      : current owner releases the resource
//               grant     : one-hot grant, zero when there is no owner
//               grant_idx : index of the current owner (valid with valid=1)
//               valid     : a grant is active
//               timeout   : one-cycle pulse on a forced release
//               Modports: master = requester side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter_4_if;
    import rr_arbiter_4_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             valid;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output valid,
        output timeout
    );

endinterface : rr_arbiter_4_if
`default_nettype wire

// File: rtl/rr_arbiter_4_dec.sv
`default_nettype none
// ============================================================================
// Module      : arb_onehot_dec
// Description : Combinational 2-to-4 one-hot decoder with enable.
//               idx : index to decode
//               en  : when low the output is all zero
//               y   : one-hot result
// Revision    : 1.0 - initial release
// ============================================================================
module arb_onehot_dec
    import rr_arbiter_4_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[idx] = 1'b1;
        end
    end

endmodule : arb_onehot_dec
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : Round-robin arbiter sharing one resource among 4 requesters.
//               A winner index is registered on the IDLE->BUSY edge and the
//               one-hot grant is decoded from it. The owner keeps the grant
//               until it raises done or drops its request; at least one idle
//               cycle separates consecutive grants. The pointer moves to the
//               requester after the released owner.
//               Ports: clk, rst (synchronous, active-high), bus (slave side
//               of rr_arbiter_4_if).
//               Optional build macro ARB_TIMEOUT_EN: adds an 8-bit hold
//               counter that forces a release after MAX_HOLD cycles of
//               ownership and pulses timeout. Without it timeout is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 15
)
(
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_4_if.slave bus
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_4: MAX_HOLD must lie in 1..255");
    end

    // Rotate the request vector so that bit 0 corresponds to ptr, take the
    // lowest set bit, then add ptr back (2-bit add wraps 3->0 naturally).
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr
    );
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        dbl = {req, req};
        rot = dbl[ptr +: N_REQ];
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = k[IDX_W-1:0];
            end
        end
        return ptr + off;
    endfunction

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_winner;
    logic             w_valid;
    logic             w_release;

    assign w_winner = rr_pick(bus.req, r_ptr);
    assign w_valid  = (r_state == ST_BUSY);

    // Voluntary release: owner signals done or withdraws its request.
    assign w_release = bus.done || !bus.req[r_idx];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] C_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] r_cnt;
    logic       r_timeout;
    logic [7:0] w_cnt_nxt;
    logic       w_timeout_nxt;
    logic       w_hit;

    assign w_hit = (r_cnt == C_HOLD_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
`ifdef ARB_TIMEOUT_EN
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = ST_BUSY;
                    w_idx_nxt   = w_winner;
`ifdef ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ST_BUSY: begin
`ifdef ARB_TIMEOUT_EN
                if (w_release || w_hit) begin
                    w_state_nxt   = ST_IDLE;
                    w_ptr_nxt     = r_idx + 2'd1;
                    // A coincident voluntary release is reported as normal.
                    w_timeout_nxt = w_hit && !w_release;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
`else
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = r_idx + 2'd1;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    arb_onehot_dec u_dec (
        .idx (r_idx),
        .en  (w_valid),
        .y   (bus.grant)
    );

    assign bus.valid     = w_valid;
    assign bus.grant_idx = r_idx;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = r_timeout;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule : rr_arbiter_4
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_4
// Description : Self-checking bench for rr_arbiter_4. A table of directed
//               vectors (inputs plus hand-computed outputs after the next
//               edge) covers reset, rotation, wrap/skip, drop release and
//               mid-grant reset; short hand-written sequences cover long
//               holds (timeout behaviour when ARB_TIMEOUT_EN is defined,
//               with MAX_HOLD=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_4;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    localparam int c_n_vec = 28;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t vecs [c_n_vec];

    rr_arbiter_4_if bus ();

    rr_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic d,
                                input logic [3:0] g, input logic [1:0] i, input logic v);
        vec_t t;
        t.rst = r; t.req = q; t.done = d; t.grant = g; t.idx = i; t.valid = v;
        return t;
    endfunction

    task automatic check_out(input string name, input logic [3:0] eg, input logic [1:0] ei,
                             input logic ev, input logic chk_idx, input logic et);
        n_tests++;
        if (bus.grant !== eg || bus.valid !== ev || bus.timeout !== et ||
            (chk_idx && bus.grant_idx !== ei)) begin
            n_fail++;
            $display("FAIL %s: got grant=%b valid=%b idx=%0d timeout=%b, want grant=%b valid=%b idx=%0d timeout=%b",
                     name, bus.grant, bus.valid, bus.grant_idx, bus.timeout, eg, ev, ei, et);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic d);
        rst      = r;
        bus.req  = q;
        bus.done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        n_tests  = 0;
        n_fail   = 0;

        //                rst  req      done  grant    idx  valid
        // reset with all requests pending, then release
        vecs[0]  = mk(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0);
        vecs[1]  = mk(1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0);
        vecs[2]  = mk(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1);
        // rotation with a one-cycle done per grant
        vecs[3]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
        vecs[4]  = mk(1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1);
        vecs[5]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
        vecs[6]  = mk(1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1);
        vecs[7]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
        vecs[8]  = mk(1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1);
        vecs[9]  = mk(1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
        vecs[10] = mk(1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1);
        // owner 0 drops request -> release, ptr=1; then owner 2 wins
        vecs[11] = mk(1'b0, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0);
        vecs[12] = mk(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
        vecs[13] = mk(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
        // non-owner requests appearing during BUSY change nothing
        vecs[14] = mk(1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1);
        // owner 2 drops with done=0 -> release, ptr=3
        vecs[15] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        vecs[16] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        // wrap/skip from ptr=3 with req=0101
        vecs[17] = mk(1'b0, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1);
        vecs[18] = mk(1'b0, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0);
        vecs[19] = mk(1'b0, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1);
        vecs[20] = mk(1'b0, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0);
        // ptr=3: owner 1 wins, then reset mid-grant, then owner 1 from ptr=0
        vecs[21] = mk(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
        vecs[22] = mk(1'b1, 4'b0010, 1'b0, 4'b0000, 2'd0, 1'b0);
        vecs[23] = mk(1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
        vecs[24] = mk(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        // done in IDLE is ignored; ptr=2 then req=1000 -> owner 3
        vecs[25] = mk(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        vecs[26] = mk(1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
        vecs[27] = mk(1'b0, 4'b1000, 1'b1, 4'b0000, 2'd0, 1'b0);

        for (int i = 0; i < c_n_vec; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done);
            check_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].valid,
                      vecs[i].valid || vecs[i].rst, 1'b0);
        end

        // State here: IDLE, ptr=0.
`ifdef ARB_TIMEOUT_EN
        // Owner 0 holds with done=0: four cycles of grant, then forced release.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'b0001, 1'b0);
            check_out($sformatf("to_hold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0001, 1'b0);
        check_out("to_forced", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'b0001, 1'b0);
        check_out("to_regrant", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'b0001, 1'b0);
            check_out($sformatf("to_hold2_%0d", k), 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        end
        // done coincides with the timeout edge: normal release, no pulse
        step(1'b0, 4'b0001, 1'b1);
        check_out("to_coincide", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        check_out("to_after", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
`else
        // Without the timeout feature the hold is unbounded.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b0001, 1'b0);
            check_out($sformatf("long_hold%0d", k), 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0001, 1'b1);
        check_out("long_release", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        // ptr=1, requests 0 and 1 pending -> owner 1
        step(1'b0, 4'b0011, 1'b0);
        check_out("after_long", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_arbiter_4
`default_nettype wire
